// File: rtl/regbank_pkg.sv
// ============================================================================
// Module : regbank_pkg
// Brief  : Shared constants and FSM state encoding for the register-bank writer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regbank_pkg;

    localparam int N_ENT  = 16;
    localparam int DATA_W = 64;
    localparam int SEL_W  = 4;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dec_4to16_onehot.sv
// ============================================================================
// Module : dec_4to16_onehot
// Brief  : One-hot entry strobe; clear counter has priority over the write select.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module dec_4to16_onehot
    import regbank_pkg::*;
(
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [SEL_W-1:0] cnt,
    input  logic             transfer,
    input  logic             clearing,
    output logic [N_ENT-1:0] strobe
);

    always_comb begin
        strobe = '0;
        if (clearing) begin
            strobe[cnt] = 1'b1;
        end else if (transfer) begin
            strobe[wr_sel] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regbank_write_demux_16x64.sv
// ============================================================================
// Module : regbank_write_demux_16x64
// Brief  : 16 x 64-bit write-steered holding registers with counter-driven clear.
//          Optional byte enables via REGBANK_BYTE_WE_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regbank_write_demux_16x64
    import regbank_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [SEL_W-1:0]        wr_sel,
    input  logic [DATA_W-1:0]       wr_data,
`ifdef REGBANK_BYTE_WE_EN
    input  logic [BE_W-1:0]         wr_be,
`endif
    output logic                    wr_done,
    input  logic                    clr_req,
    output logic                    clr_busy,
    output logic [N_ENT*DATA_W-1:0] q_flat,
    output logic [N_ENT-1:0]        q_vld
);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [SEL_W-1:0]               r_cnt;
    logic [SEL_W-1:0]               w_cnt_nxt;
    logic [N_ENT-1:0][DATA_W-1:0]   r_ent;
    logic [N_ENT-1:0]               r_vld;
    logic                           r_done;
    logic                           w_transfer;
    logic                           w_clearing;
    logic [N_ENT-1:0]               w_strobe;
    logic [DATA_W-1:0]              w_mask;
    logic                           w_any_be;

    assign w_clearing = (r_state == ST_CLEAR);
    assign wr_ready   = (r_state == ST_IDLE) & ~clr_req;
    assign w_transfer = wr_valid & wr_ready;

`ifdef REGBANK_BYTE_WE_EN
    always_comb begin
        w_mask = '0;
        for (int k = 0; k < BE_W; k++) begin
            w_mask[k*8 +: 8] = {8{wr_be[k]}};
        end
    end
    assign w_any_be = |wr_be;
`else
    assign w_mask   = '1;
    assign w_any_be = 1'b1;
`endif

    dec_4to16_onehot u_dec (
        .wr_sel   (wr_sel),
        .cnt      (r_cnt),
        .transfer (w_transfer),
        .clearing (w_clearing),
        .strobe   (w_strobe)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                // Counter wraps naturally to 0 when entry 15 is cleared.
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == SEL_W'(N_ENT - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_transfer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ent <= '0;
            r_vld <= '0;
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                if (w_strobe[i]) begin
                    if (w_clearing) begin
                        r_ent[i] <= '0;
                        r_vld[i] <= 1'b0;
                    end else begin
                        r_ent[i] <= (r_ent[i] & ~w_mask) | (wr_data & w_mask);
                        if (w_any_be) begin
                            r_vld[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign q_flat   = r_ent;
    assign q_vld    = r_vld;
    assign wr_done  = r_done;
    assign clr_busy = w_clearing;

endmodule

`default_nettype wire

// File: tb/tb_regbank_write_demux_16x64.sv
// ============================================================================
// Module : tb_regbank_write_demux_16x64
// Brief  : Directed self-checking bench; byte-enable scenarios under REGBANK_BYTE_WE_EN.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_regbank_write_demux_16x64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [3:0]    wr_sel;
    logic [63:0]   wr_data;
    logic [7:0]    wr_be;
    logic          wr_done;
    logic          clr_req;
    logic          clr_busy;
    logic [1023:0] q_flat;
    logic [15:0]   q_vld;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regbank_write_demux_16x64 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
`ifdef REGBANK_BYTE_WE_EN
        .wr_be    (wr_be),
`endif
        .wr_done  (wr_done),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .q_flat   (q_flat),
        .q_vld    (q_vld)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_valid = 1'b0; wr_sel = '0; wr_data = '0;
        wr_be = 8'hFF; clr_req = 1'b0;
        tick(); tick();
        checks++;
        if (q_flat !== '0) begin errors++; $display("FAIL reset_q_flat got nonzero want 0"); end
        checks++;
        if (q_vld !== 16'h0000) begin errors++; $display("FAIL reset_q_vld got %h want 0000", q_vld); end
        checks++;
        if (clr_busy !== 1'b0 || wr_done !== 1'b0) begin
            errors++; $display("FAIL reset_flags got busy=%b done=%b want 0 0", clr_busy, wr_done);
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
    endtask

    task automatic test_single_write();
        wr_valid = 1'b1; wr_sel = 4'hA; wr_data = 64'hDEAD_BEEF_0123_4567;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        checks++;
        if (q_flat[703:640] !== 64'hDEAD_BEEF_0123_4567) begin
            errors++; $display("FAIL single_data got %h want DEADBEEF01234567", q_flat[703:640]);
        end
        checks++;
        if (q_vld !== 16'h0400) begin errors++; $display("FAIL single_vld got %h want 0400", q_vld); end
        checks++;
        if (wr_done !== 1'b1) begin errors++; $display("FAIL single_done got %b want 1", wr_done); end
        tick();
        checks++;
        if (wr_done !== 1'b0) begin errors++; $display("FAIL single_done_clr got %b want 0", wr_done); end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        for (int s = 0; s < 16; s++) begin
            wr_valid = 1'b1; wr_sel = 4'(s); wr_data = 64'(s) * 64'h1111;
            tick();
            if (wr_done === 1'b1) ndone++;
        end
        wr_valid = 1'b0;
        checks++;
        if (ndone != 16) begin errors++; $display("FAIL b2b_done_count got %0d want 16", ndone); end
        checks++;
        if (q_vld !== 16'hFFFF) begin errors++; $display("FAIL b2b_vld got %h want FFFF", q_vld); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (q_flat[i*64 +: 64] !== 64'(i) * 64'h1111) begin
                errors++;
                $display("FAIL b2b_entry%0d got %h want %h", i, q_flat[i*64 +: 64], 64'(i) * 64'h1111);
            end
        end
        tick();
    endtask

    task automatic test_clear_vs_write();
        int nbusy = 0;
        int guard = 0;
        logic bad = 1'b0;
        clr_req = 1'b1; wr_valid = 1'b1; wr_sel = 4'h5; wr_data = 64'hCAFE_F00D_5555_AAAA;
        #1;
        checks++;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL clr_beats_wr ready got %b want 0", wr_ready); end
        tick();
        clr_req = 1'b0;
        while (clr_busy === 1'b1 && guard < 40) begin
            nbusy++;
            if (wr_ready !== 1'b0 || wr_done !== 1'b0) bad = 1'b1;
            // A request mid-sequence must not restart or extend it.
            clr_req = (nbusy == 5);
            tick();
            guard++;
        end
        clr_req = 1'b0;
        checks++;
        if (nbusy != 16) begin errors++; $display("FAIL clr_busy_cycles got %0d want 16", nbusy); end
        checks++;
        if (bad) begin errors++; $display("FAIL clr_no_accept got ready/done high want low"); end
        checks++;
        if (q_vld !== 16'h0000 || q_flat !== '0) begin
            errors++; $display("FAIL clr_result got vld=%h want 0000 and zero data", q_vld);
        end
        checks++;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL clr_idle_ready got %b want 1", wr_ready); end
        tick();
        wr_valid = 1'b0;
        checks++;
        if (q_vld !== 16'h0020 || q_flat[383:320] !== 64'hCAFE_F00D_5555_AAAA || wr_done !== 1'b1) begin
            errors++;
            $display("FAIL held_write got vld=%h e5=%h done=%b want 0020 CAFEF00D5555AAAA 1",
                     q_vld, q_flat[383:320], wr_done);
        end
        tick();
    endtask

    task automatic test_reset_midclear();
        wr_valid = 1'b1; wr_sel = 4'hF; wr_data = 64'h1234_5678_9ABC_DEF0;
        tick();
        wr_sel = 4'hE; wr_data = 64'h0F0F_0F0F_0F0F_0F0F;
        tick();
        wr_valid = 1'b0; clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int c = 1; c < 7; c++) tick();
        checks++;
        if (clr_busy !== 1'b1 || q_vld[15] !== 1'b1) begin
            errors++; $display("FAIL midclear_pre got busy=%b vld15=%b want 1 1", clr_busy, q_vld[15]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0) begin errors++; $display("FAIL midclear_busy got %b want 0", clr_busy); end
        checks++;
        if (q_flat !== '0 || q_vld !== 16'h0000) begin
            errors++; $display("FAIL midclear_state got vld=%h want 0000 and zero data", q_vld);
        end
        #2 rst_n = 1'b1;
        tick();
        checks++;
        if (wr_ready !== 1'b1 || clr_busy !== 1'b0) begin
            errors++; $display("FAIL midclear_idle got ready=%b busy=%b want 1 0", wr_ready, clr_busy);
        end
    endtask

`ifdef REGBANK_BYTE_WE_EN
    task automatic test_byte_we();
        wr_valid = 1'b1; wr_sel = 4'h3; wr_data = 64'hFFFF_FFFF_FFFF_FFFF; wr_be = 8'hFF;
        tick();
        wr_data = 64'h0; wr_be = 8'h0F;
        tick();
        wr_valid = 1'b0; wr_be = 8'hFF;
        checks++;
        if (q_flat[255:192] !== 64'hFFFF_FFFF_0000_0000) begin
            errors++; $display("FAIL be_partial got %h want FFFFFFFF00000000", q_flat[255:192]);
        end
        wr_valid = 1'b1; wr_sel = 4'h7; wr_data = 64'h1111_2222_3333_4444; wr_be = 8'h00;
        tick();
        wr_valid = 1'b0; wr_be = 8'hFF;
        checks++;
        if (wr_done !== 1'b1 || q_vld[7] !== 1'b0 || q_flat[511:448] !== 64'h0) begin
            errors++;
            $display("FAIL be_zero got done=%b vld7=%b e7=%h want 1 0 0", wr_done, q_vld[7], q_flat[511:448]);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_clear_vs_write();
        test_reset_midclear();
`ifdef REGBANK_BYTE_WE_EN
        test_byte_we();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
